// File: rtl/mole_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mole_scheduler
// Description : Whack-a-mole game sequencer. Lights one hole at a time,
//               counts hits and timeouts, ends the game after MAX_MISS misses.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_scheduler #(
  parameter int          GAP_MS    = 300,
  parameter int          UP_MS     = 800,
  parameter int          MAX_MISS  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       clk_1kHz,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       hit_pulse,
  output logic       game_over
);

  localparam logic [11:0] c_GAP_LAST  = 12'(GAP_MS - 1);
  localparam logic [11:0] c_UP_LAST   = 12'(UP_MS - 1);
  localparam logic [7:0]  c_MAX_MISS  = 8'(MAX_MISS);
  // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_UP   = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;

  logic        r_clk_1khz_q;
  logic        r_start_q;
  logic [3:0]  r_btn_q;
  logic        w_tick;
  logic        w_start_edge;
  logic [3:0]  w_btn_edge;

  logic [15:0] r_lfsr, w_lfsr_nxt;
  logic [11:0] r_ms_cnt, w_ms_cnt_nxt;
  logic [7:0]  r_score, w_score_nxt;
  logic [7:0]  r_misses, w_misses_nxt, w_misses_inc;
  logic [1:0]  r_hole, w_hole_nxt, w_hole_cand;
  logic [3:0]  r_mole, w_mole_nxt;
  logic        r_hit_pulse;
  logic        w_hit;
  logic        w_timeout;

  // Registered copies of the slow inputs for rising-edge detection
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_clk_1khz_q <= 1'b0;
      r_start_q    <= 1'b0;
      r_btn_q      <= 4'b0000;
    end else begin
      r_clk_1khz_q <= clk_1kHz;
      r_start_q    <= start;
      r_btn_q      <= btn;
    end
  end

  assign w_tick       = clk_1kHz & ~r_clk_1khz_q;
  assign w_start_edge = start & ~r_start_q;
  assign w_btn_edge   = btn & ~r_btn_q;

  // Free-running LFSR; its low bits pick the next hole
  assign w_lfsr_nxt  = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_LFSR_TAPS) : (r_lfsr >> 1);
  // Never light the same hole twice in a row
  assign w_hole_cand = (r_lfsr[1:0] == r_hole) ? (r_lfsr[1:0] + 2'd1) : r_lfsr[1:0];

  // Next-state and datapath decisions; a hit takes priority over a timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_ms_cnt_nxt = r_ms_cnt;
    w_score_nxt  = r_score;
    w_misses_nxt = r_misses;
    w_hole_nxt   = r_hole;
    w_hit        = 1'b0;
    w_timeout    = 1'b0;
    w_misses_inc = (r_misses == 8'hFF) ? r_misses : (r_misses + 8'd1);

    case (r_state)
      S_IDLE, S_OVER: begin
        if (w_start_edge) begin
          w_state_nxt  = S_GAP;
          w_ms_cnt_nxt = 12'd0;
          w_score_nxt  = 8'd0;
          w_misses_nxt = 8'd0;
        end
      end
      S_GAP: begin
        if (w_tick) begin
          if (r_ms_cnt == c_GAP_LAST) begin
            w_state_nxt  = S_UP;
            w_ms_cnt_nxt = 12'd0;
            w_hole_nxt   = w_hole_cand;
          end else begin
            w_ms_cnt_nxt = r_ms_cnt + 12'd1;
          end
        end
      end
      S_UP: begin
        // Only a fresh press on the lit hole counts; held buttons give no edge
        w_hit     = |(w_btn_edge & r_mole);
        w_timeout = w_tick && (r_ms_cnt == c_UP_LAST);
        if (w_hit) begin
          w_score_nxt  = (r_score == 8'hFF) ? r_score : (r_score + 8'd1);
          w_ms_cnt_nxt = 12'd0;
          w_state_nxt  = S_GAP;
        end else if (w_timeout) begin
          w_misses_nxt = w_misses_inc;
          w_ms_cnt_nxt = 12'd0;
          w_state_nxt  = (w_misses_inc == c_MAX_MISS) ? S_OVER : S_GAP;
        end else if (w_tick) begin
          w_ms_cnt_nxt = r_ms_cnt + 12'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_mole_nxt = (w_state_nxt == S_UP) ? (4'b0001 << w_hole_nxt) : 4'b0000;
  end

  // State, counters, hole memory and registered outputs
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ms_cnt    <= 12'd0;
      r_score     <= 8'd0;
      r_misses    <= 8'd0;
      r_hole      <= 2'd0;
      r_mole      <= 4'b0000;
      r_hit_pulse <= 1'b0;
      r_lfsr      <= LFSR_SEED;
    end else begin
      r_state     <= w_state_nxt;
      r_ms_cnt    <= w_ms_cnt_nxt;
      r_score     <= w_score_nxt;
      r_misses    <= w_misses_nxt;
      r_hole      <= w_hole_nxt;
      r_mole      <= w_mole_nxt;
      r_hit_pulse <= w_hit;
      r_lfsr      <= w_lfsr_nxt;
    end
  end

  assign mole      = r_mole;
  assign score     = r_score;
  assign misses    = r_misses;
  assign hit_pulse = r_hit_pulse;
  assign game_over = (r_state == S_OVER);

endmodule
`default_nettype wire

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 The block SHALL have parameter GAP_MS, default 300, giving the blank interval between moles in ms ticks (range 1..4095).
REQ-002 The block SHALL have parameter UP_MS, default 800, giving how long a mole stays lit in ms ticks (range 1..4095).
REQ-003 The block SHALL have parameter MAX_MISS, default 3, giving the number of misses that ends the game (range 1..255).
REQ-004 The block SHALL have parameter LFSR_SEED, default 16'hACE1, giving the LFSR reset value (must be nonzero).
REQ-005 Port clk_100MHz  input  1  sole clock; all state is updated on its rising edge.
REQ-006 Port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 Port clk_1kHz  input  1  1 kHz square wave from the divider, synchronous to clk_100MHz.
REQ-008 Port start  input  1  level input, debounced and synchronous; its rising edge starts or restarts a game.
REQ-009 Port btn  input  4  hole buttons, debounced and synchronous; bit i corresponds to hole i.
REQ-010 Port mole  output  4  one-hot lit hole; 0 means no mole is lit.
REQ-011 Port score  output  8  hit count for the current game.
REQ-012 Port misses  output  8  miss count for the current game.
REQ-013 Port hit_pulse  output  1  high for one cycle on each hit.
REQ-014 Port game_over  output  1  high while in the OVER state.

Function
REQ-015 tick SHALL be asserted for one cycle when clk_1kHz is 1 and was 0 in the previous cycle; one tick is one ms.
REQ-016 Rising edges of start and of each btn bit SHALL be detected against a registered copy, with the same one-cycle pulse rule as tick.
REQ-017 The FSM SHALL have the states IDLE, GAP, UP and OVER; encoding is free.
REQ-018 In IDLE, a start edge SHALL clear score, misses and ms_cnt and move to GAP; mole=0.
REQ-019 In GAP, ms_cnt SHALL increment on each tick; when a tick arrives with ms_cnt==GAP_MS-1, the FSM SHALL move to UP and clear ms_cnt.
REQ-020 On GAP->UP, hole = lfsr[1:0]; if hole equals the previous hole, hole SHALL become (hole+1) mod 4. The previous hole resets to 0.
REQ-021 mole SHALL be registered and equal 1<<hole during UP, and 0 in every other state.
REQ-022 In UP, a btn edge on the lit hole SHALL count as a hit: score+1 (saturating at 255), hit_pulse=1 for one cycle, ms_cnt cleared, next state GAP.
REQ-023 In UP, a btn edge on any unlit hole SHALL be ignored; a button already held when UP is entered SHALL NOT count as a hit.
REQ-024 In UP, a tick with ms_cnt==UP_MS-1 SHALL count as a miss: misses+1 (saturating at 255), ms_cnt cleared.
REQ-025 After a miss, the next state SHALL be OVER if the new misses value equals MAX_MISS, otherwise GAP.
REQ-026 If a hit and a timeout occur in the same cycle, the hit SHALL win and no miss is counted.
REQ-027 In OVER, game_over=1 and mole=0; score and misses SHALL hold; a start edge SHALL behave as in REQ-018.
REQ-028 A start edge in GAP or UP SHALL be ignored.
REQ-029 The LFSR SHALL be a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1, advancing every clk_100MHz cycle (free-running).
REQ-030 ms_cnt SHALL be 12 bits wide and SHALL never exceed max(GAP_MS,UP_MS)-1.

Reset
REQ-031 While reset=0, the block SHALL asynchronously force: state=IDLE, mole=0, score=0, misses=0, hit_pulse=0, game_over=0, ms_cnt=0, lfsr=LFSR_SEED, edge-detect registers=0.
REQ-032 Reset asserted mid-game SHALL abort the game immediately; after release the block SHALL wait in IDLE for a start edge.
REQ-033 Because the edge-detect registers clear to 0, a start held high through reset release SHALL produce one start edge on the first clock after release.

Verification (bench with GAP_MS=3, UP_MS=5, MAX_MISS=3; clk_1kHz driven as a 20-cycle square wave)
REQ-034 Check reset and start: reset=0 then release -> all outputs 0; start pulse -> mole goes nonzero exactly on the 3rd tick.
REQ-035 Check a hit: press the lit hole 2 ticks into UP -> hit_pulse for 1 cycle, score=1, mole=0 on the next cycle, and a new mole after 3 ticks.
REQ-036 Check wrong button and miss: press an unlit hole -> no change; on the 5th tick misses=1 and the FSM enters GAP; the 3rd miss -> game_over=1 and score held.
REQ-037 Check the hit/timeout tie: press the lit hole in the same cycle as the 5th tick -> score+1 and misses unchanged; also hold btn across GAP->UP -> no hit counted.
REQ-038 Check hole selection and reset: over 200 moles, no hole repeats consecutively and every hole appears; reset=0 mid-UP -> mole=0 asynchronously, then IDLE.
REQ-039 Check saturation: force 260 hits -> score stays at 255.
